// File: rtl/serial_link_pkg.sv
// Definitions shared by both ends of the serial link: the receive FSM state
// encoding, the default word width and the bit-counter width helper.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    STALL = 2'd2
  } rx_state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must hold every value 0..width, hence width+1 states.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_rx_shift_reg.sv
// Shift register plus bit counter for the receive side. Offers a combinational
// preview of the word with the current bit inserted, so the owner can move a
// completed word straight to its output slot on the capturing edge.
module serial_rx_shift_reg
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             insert,       // shift bit_in into the current word
  input  logic             restart,      // drop the current word, bit_in becomes its first bit
  input  logic             clear,        // empty the register
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] ins_word,     // word as it would be after inserting bit_in
  output logic             ins_complete  // inserting bit_in fills the word
);

  logic [WIDTH-1:0] start_word;

  // MSB-first shifts left so the first bit ends in bit WIDTH-1; LSB-first
  // shifts right so the first bit ends in bit 0 after WIDTH insertions.
  always_comb begin
    ins_word   = '0;
    start_word = '0;
    if (MSB_FIRST) begin
      ins_word   = {word[WIDTH-2:0], bit_in};
      start_word = {{(WIDTH-1){1'b0}}, bit_in};
    end else begin
      ins_word   = {bit_in, word[WIDTH-1:1]};
      start_word = {bit_in, {(WIDTH-1){1'b0}}};
    end
  end

  assign ins_complete = (count == CW'(WIDTH - 1));

  // Register update: reset, then clear, then restart, then normal insert.
  always_ff @(posedge clk) begin
    if (rst) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (restart) begin
      word  <= start_word;
      count <= CW'(1);
    end else if (insert) begin
      word  <= ins_word;
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Rebuilds WIDTH-bit words from the serializer's bit stream, holds one
// finished word while the consumer stalls, and reports framing/overrun faults.
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both 1; out_data does not change while out_valid=1 and
// out_ready=0.
module serial_word_deserializer
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = count_width(WIDTH)
) (
  input  logic             input_clock1_clk_1,
  input  logic             input_push_button1_reset_1,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             frame_start,
  input  logic             clear_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    bit_count,
  output logic             framing_err,
  output logic             overrun_err,
  output rx_state_t        state_dbg
);

  logic clk;
  logic rst;
  assign clk = input_clock1_clk_1;
  assign rst = input_push_button1_reset_1;

  rx_state_t        state;
  rx_state_t        state_next;
  logic             sr_insert;
  logic             sr_restart;
  logic             sr_clear;
  logic [WIDTH-1:0] sr_word;
  logic [WIDTH-1:0] sr_ins_word;
  logic             sr_ins_complete;
  logic             slot_free;
  logic             slot_load;
  logic [WIDTH-1:0] slot_word;
  logic             set_framing;
  logic             set_overrun;

  serial_rx_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk          (clk),
    .rst          (rst),
    .insert       (sr_insert),
    .restart      (sr_restart),
    .clear        (sr_clear),
    .bit_in       (serial_in),
    .word         (sr_word),
    .count        (bit_count),
    .ins_word     (sr_ins_word),
    .ins_complete (sr_ins_complete)
  );

  // The slot can take a word if empty or being emptied on this same edge.
  assign slot_free = !out_valid || out_ready;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus shift-register, slot and flag controls.
  always_comb begin
    state_next  = state;
    sr_insert   = 1'b0;
    sr_restart  = 1'b0;
    sr_clear    = 1'b0;
    slot_load   = 1'b0;
    slot_word   = sr_ins_word;
    set_framing = 1'b0;
    set_overrun = 1'b0;
    case (state)
      IDLE: begin
        // Unaligned bits are discarded until a frame start arrives.
        if (shift_en && frame_start) begin
          sr_restart = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        if (shift_en) begin
          if (frame_start) begin
            // Realign on the new frame; the partial word is lost.
            sr_restart  = 1'b1;
            set_framing = 1'b1;
          end else if (sr_ins_complete) begin
            if (slot_free) begin
              slot_load  = 1'b1;
              slot_word  = sr_ins_word;
              sr_clear   = 1'b1;
              state_next = IDLE;
            end else begin
              sr_insert  = 1'b1;
              state_next = STALL;
            end
          end else begin
            sr_insert = 1'b1;
          end
        end
      end
      STALL: begin
        // No room anywhere for a new bit; it is dropped even if the held
        // word leaves on this edge.
        if (shift_en) set_overrun = 1'b1;
        if (slot_free) begin
          slot_load  = 1'b1;
          slot_word  = sr_word;
          sr_clear   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output slot: load a finished word, or empty on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (slot_load) begin
      out_data  <= slot_word;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flags; a new fault outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      framing_err <= set_framing || (framing_err && !clear_err);
      overrun_err <= set_overrun || (overrun_err && !clear_err);
    end
  end

endmodule

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Receive-side stage that consumes the serial bit stream produced by the parallel-to-serial serializer and its load/shift strobe, rebuilds WIDTH-bit words, and presents them to the downstream register/LED stage over a valid/ready handshake. It tracks frame alignment, buffers one completed word while the consumer stalls, and flags framing and overrun faults.

## Interface
Parameters:
- WIDTH, 4, bits per word; legal range 2..16.
- MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.

Ports:
- input_clock1_clk_1  in  1  system clock; all state updates on its rising edge.
- input_push_button1_reset_1  in  1  synchronous reset, active-high.
- serial_in  in  1  serial data bit, sampled only when shift_en=1.
- shift_en  in  1  bit strobe; one cycle high per bit.
- frame_start  in  1  qualifies the current shift_en bit as the first bit of a word; ignored when shift_en=0.
- clear_err  in  1  synchronous clear of the sticky error flags.
- out_data  out  WIDTH  assembled word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both 1.
- bit_count  out  clog2(WIDTH+1)  bits collected in the current partial word.
- framing_err  out  1  sticky; frame_start seen mid-word.
- overrun_err  out  1  sticky; bit dropped because both the shift register and the output slot were full.

## Operation
- Reset values: state IDLE, shift register 0, bit_count 0, out_data 0, out_valid 0, framing_err 0, overrun_err 0.
- States: IDLE, RECV, STALL.
- IDLE: shift_en=1 with frame_start=1 stores the bit, sets bit_count=1, and moves to RECV. When WIDTH bits are complete, the state follows the RECV completion rule instead. shift_en=1 with frame_start=0 discards the bit and leaves the flags unchanged, so the stage waits for alignment.
- RECV: each shift_en stores serial_in at the position selected by MSB_FIRST and increments bit_count.
  - On the WIDTH-th bit the word is complete.
  - If the output slot is free, or freed in the same cycle (out_valid and out_ready), the word moves to out_data, out_valid=1, bit_count=0, and the state goes to IDLE.
  - Otherwise the state goes to STALL holding the full word, with bit_count=WIDTH.
- RECV, frame_start=1 with bit_count>0: the partial word is discarded, framing_err is set, and the bit is stored as bit 1 of a new word (bit_count=1).
- STALL: once the output slot frees (handshake this cycle, or out_valid already 0), the held word moves to out_data the same edge, out_valid stays or becomes 1, bit_count=0, and the state goes to IDLE.
- STALL, shift_en=1: the bit is dropped and overrun_err is set. If the slot frees in that same cycle, the transfer still happens and the bit is still dropped.
- Output slot: out_data is stable while out_valid=1 and out_ready=0. A handshake without a new word clears out_valid next edge.
- Errors: clear_err clears both flags next edge. If a set condition coincides with clear_err, set wins.
- Reset has priority over all inputs, including mid-word and in STALL. The partial word and the held word are lost.

## Timing
- Every bit is captured on the edge where shift_en=1.
- Latency: out_valid rises on the same edge that captures the WIDTH-th bit when the slot is free, so the word is visible in the following cycle.
- Throughput: one word per WIDTH strobes. Back-to-back strobes every cycle are legal and sustain full rate if out_ready stays high.
- A STALL lasts at most until the first consumer handshake. The transfer happens on that handshake edge, with no bubble cycle.
- Flags are registered and update one edge after their cause.

## Structure
- Shared package serial_link_pkg holds:
  - state enum {IDLE, RECV, STALL}
  - default WIDTH=4
  - a count-width function clog2(WIDTH+1)
- The serializer side imports serial_link_pkg as well.
- One sub-module is natural: serial_rx_shift_reg, a parameterised shift register with bit counter providing insert, clear and complete outputs. The FSM, output slot and error flags stay in the top.

## Test plan
- WIDTH=4, MSB_FIRST=1, out_ready=1; frame_start with first bit, bits 1,0,1,1 on consecutive strobes -> out_data=4'hB, out_valid=1 for exactly one cycle, both flags 0.
- MSB_FIRST=0, same bit sequence -> out_data=4'hD.
- out_ready=0; send words 4'hA then 4'h5 -> out_data holds 4'hA and the state is STALL. A 9th strobe sets overrun_err. Raising out_ready -> 4'hA accepted, 4'h5 presented next cycle, out_valid stays 1.
- frame_start after 2 bits, then 4 bits 0,1,1,0 -> framing_err=1, out_data=4'h6.
- Reset asserted after 3 bits with out_valid=1 -> next cycle all outputs 0. A subsequent clean frame 1,1,1,1 gives 4'hF.
- clear_err and overrun condition in the same cycle -> overrun_err remains 1. clear_err alone next cycle -> overrun_err=0.
